// File: rtl/mips_mem_loader.sv
// Host-side loader/dumper for the pipe_MIPS32 memory: LOAD streams words in, RUN releases the core
// and waits for HLT, DUMP streams a region out. Define MIPS_MEM_LOADER_CHECKSUM_EN to append an XOR word.
module mips_mem_loader #(
  parameter int unsigned AW          = 10,
  parameter int unsigned DW          = 32,
  parameter int unsigned RUN_TIMEOUT = 4096
) (
  input  logic          clk1_i,
  input  logic          reset_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_op_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [AW-1:0] cmd_len_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_data_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic          m_last_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          core_start_o,
  input  logic          core_halted_i,
  output logic          busy_o,
  output logic          err_o
);

  localparam int unsigned TW = $clog2(RUN_TIMEOUT + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StRd    = 3'd4;
  localparam logic [2:0] StOut   = 3'd5;
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] StCsum  = 3'd6;
`endif

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          first_q, first_d;
  logic          rd_pend_q, rd_pend_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          err_q, err_d;
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  assign busy_o      = (state_q != StIdle);
  assign cmd_ready_o = (state_q == StIdle) & ~reset_i;
  assign err_o       = err_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    first_d      = 1'b0;
    rd_pend_d    = 1'b0;
    dout_d       = dout_q;
    err_d        = err_q;
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    s_ready_o    = 1'b0;
    m_valid_o    = 1'b0;
    m_data_o     = '0;
    m_last_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    core_start_o = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          addr_d = cmd_addr_i;
          cnt_d  = cmd_len_i;
          case (cmd_op_i)
            2'd0: state_d = StLoad;
            2'd1: state_d = StStart;
            2'd2: begin
              state_d = StRd;
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
              csum_d  = '0;
`endif
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StLoad: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          mem_we_o    = 1'b1;
          mem_addr_o  = addr_q;
          mem_wdata_o = s_data_i;
          addr_d      = addr_q + AW'(1);
          cnt_d       = cnt_q - AW'(1);
          if (cnt_q == '0) state_d = StIdle;
        end
      end
      StStart: begin
        core_start_o = 1'b1;
        timer_d      = '0;
        first_d      = 1'b1;
        state_d      = StWait;
      end
      StWait: begin
        timer_d = timer_q + TW'(1);
        // HALTED is still stale from the previous program on the first cycle after the start pulse
        if (core_halted_i && !first_q) begin
          state_d = StIdle;
        end else if (timer_q == TW'(RUN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StRd: begin
        mem_re_o   = 1'b1;
        mem_addr_o = addr_q;
        rd_pend_d  = 1'b1;
        state_d    = StOut;
      end
      StOut: begin
        m_valid_o = 1'b1;
        // First OUT cycle forwards the fresh read word; later stall cycles replay the capture
        m_data_o  = rd_pend_q ? mem_rdata_i : dout_q;
        if (rd_pend_q) dout_d = mem_rdata_i;
`ifndef MIPS_MEM_LOADER_CHECKSUM_EN
        m_last_o  = (cnt_q == '0);
`endif
        if (m_ready_i) begin
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ m_data_o;
`endif
          if (cnt_q == '0) begin
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StIdle;
`endif
          end else begin
            addr_d  = addr_q + AW'(1);
            cnt_d   = cnt_q - AW'(1);
            state_d = StRd;
          end
        end
      end
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
      StCsum: begin
        m_valid_o = 1'b1;
        m_data_o  = csum_q;
        m_last_o  = 1'b1;
        if (m_ready_i) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk1_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      first_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      dout_q    <= '0;
      err_q     <= 1'b0;
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      first_q   <= first_d;
      rd_pend_q <= rd_pend_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips_mem_loader.sv
// Randomized bench for mips_mem_loader: a synchronous memory, a model core and a reference
// memory image predict every written word, dumped beat, checksum and RUN outcome.
module tb_mips_mem_loader;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int HaltAfter = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          core_start, core_halted, busy, err;

  always #5 clk = ~clk;

  mips_mem_loader #(.AW(AW), .DW(DW), .RUN_TIMEOUT(16)) dut (
    .clk1_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .core_start_o(core_start), .core_halted_i(core_halted),
    .busy_o(busy), .err_o(err)
  );

  // Core memory, activity counters and a model core that halts HaltAfter cycles after start
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [AW-1:0] re_log [$];
  int we_cnt = 0, re_cnt = 0, start_cnt = 0;
  int run_cnt = -1;
  logic stuck = 1'b0;

  assign core_halted = stuck ? 1'b0 : (run_cnt < 1 || run_cnt >= HaltAfter);

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      re_log.push_back(mem_addr);
      re_cnt <= re_cnt + 1;
    end
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      run_cnt   <= 0;
    end else if (run_cnt >= 0 && run_cnt < 1000) begin
      run_cnt <= run_cnt + 1;
    end
    if (!stuck && run_cnt == HaltAfter - 1) mem[198] <= 32'd5040;
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance
  task automatic issue(input logic [1:0] op, input int addr, input int len);
    cmd_op    = op;
    cmd_addr  = addr[AW-1:0];
    cmd_len   = len[AW-1:0];
    cmd_valid = 1'b1;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = AW'($urandom);
  endtask

  task automatic load(input int addr, input logic [DW-1:0] w[$], input bit gaps);
    int idx = 0;
    int guard = 0;
    issue(2'd0, addr, w.size() - 1);
    while (idx < w.size() && guard < 500) begin
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = s_valid ? w[idx] : $urandom;
      #1;
      if (s_valid && s_ready) begin
        ref_mem[(addr + idx) % 1024] = w[idx];
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0;
    check("load_beats", idx, w.size());
    check("load_done_idle", busy, 0);
  endtask

  // mode 0: random m_ready, 1: repeating 1,0,0,1 over valid cycles, 2: always ready
  task automatic dump(input int addr, input int len, input int mode);
    logic [DW-1:0] exp[$];
    logic [DW-1:0] csum = '0;
    logic [DW-1:0] held = '0;
    int pat[4] = '{1, 0, 0, 1};
    int beat = 0, pc = 0, guard = 0;
    bit have = 0;
    logic rdy;
    for (int i = 0; i <= len; i++) begin
      exp.push_back(ref_mem[(addr + i) % 1024]);
      csum ^= ref_mem[(addr + i) % 1024];
    end
`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
    exp.push_back(csum);
`endif
    re_log.delete();
    issue(2'd2, addr, len);
    while (beat < exp.size() && guard < 400) begin
      #1;
      if (m_valid) begin
        rdy = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 1) ? (pat[pc % 4] != 0) : 1'b1;
        pc++;
        m_ready = rdy;
        if (have) check("dump_stable", m_data, held);
        held = m_data;
        have = 1;
        if (rdy) begin
          check("dump_data", m_data, exp[beat]);
          check("dump_last", m_last, beat == exp.size() - 1);
          beat++;
          have = 0;
        end
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      guard++;
    end
    m_ready = 1'b0;
    check("dump_beats", beat, exp.size());
    check("dump_done_idle", busy, 0);
  endtask

  logic [DW-1:0] prog[11] = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
                              32'h0e94a000, 32'h14431000, 32'h1c630001, 32'h0e94a000,
                              32'h3a1460ff, 32'h2542fffe, 32'hfc000000};

  initial begin
    logic [DW-1:0] w[$];
    int base, n, we0, re0, st0;

    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    reset = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_len = 0;
    s_valid = 0; s_data = 0; m_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", {cmd_ready, s_ready, m_valid, m_last, mem_we, mem_re, core_start, busy,
                          err, m_data, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Factorial program at address 0
    w.delete();
    for (int i = 0; i < 11; i++) w.push_back(prog[i]);
    we0 = we_cnt;
    load(0, w, 1);
    check("fact_we_pulses", we_cnt - we0, 11);
    for (int i = 0; i < 11; i++) check($sformatf("fact_mem%0d", i), mem[i], prog[i]);

    // Randomized load/dump round trips, including wrap past 1023
    for (int t = 0; t < 5; t++) begin
      base = (t == 0) ? 1020 : $urandom_range(0, 1023);
      n    = $urandom_range(1, 12);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      load(base, w, 1);
      dump(base, n - 1, 0);
    end

    // RUN with a core that halts, stale HALTED masked on the first wait cycle
    w.delete();
    w.push_back(32'd7);
    load(200, w, 0);
    st0 = start_cnt;
    issue(2'd1, 0, 0);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("run_start_pulses", start_cnt - st0, 1);
    check("run_busy_cycles_ge", n >= HaltAfter, 1);
    check("run_busy_cycles_le", n <= HaltAfter + 3, 1);
    check("run_err", err, 0);
    ref_mem[198] = 32'd5040;
    dump(198, 0, 2);

    // Wrapping dump under backpressure
    w.delete();
    for (int i = 0; i < 4; i++) w.push_back($urandom);
    load(1022, w, 0);
    dump(1022, 3, 1);
    check("wrap_reads", re_log.size(), 4);
    if (re_log.size() == 4) begin
      check("wrap_rd0", re_log[0], 1022);
      check("wrap_rd1", re_log[1], 1023);
      check("wrap_rd2", re_log[2], 0);
      check("wrap_rd3", re_log[3], 1);
    end

`ifdef MIPS_MEM_LOADER_CHECKSUM_EN
    w.delete();
    w.push_back(32'h1); w.push_back(32'h2); w.push_back(32'h4);
    load(300, w, 0);
    dump(300, 2, 0);
`endif

    // RUN timeout with HALTED stuck low
    stuck = 1'b1;
    issue(2'd1, 0, 0);
    n = 0;
    while (!err && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("timeout_err", err, 1);
    check("timeout_within_18", n <= 18, 1);
    #1;
    check("timeout_idle", busy, 0);
    check("timeout_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    stuck = 1'b0;

    // Reset mid-LOAD after three beats
    issue(2'd0, 500, 20);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      @(negedge clk);
    end
    we0 = we_cnt;
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {cmd_ready, s_ready, m_valid, m_last, mem_we, mem_re, core_start,
                              busy, err, mem_addr, mem_wdata}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check("rst_mid_no_we", we_cnt - we0, 0);
    check("rst_mid_err_clear", err, 0);

    // Reserved op
    we0 = we_cnt; re0 = re_cnt; st0 = start_cnt;
    issue(2'd3, 5, 5);
    #1;
    check("rsvd_err", err, 1);
    check("rsvd_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("rsvd_no_activity", {32'(we_cnt - we0), 32'(re_cnt - re0)}, 0);
    check("rsvd_no_start", start_cnt - st0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
